// File: rtl/warp_reg_alloc_pkg.sv
// Shared types and width helpers for the warp register allocator.
package warp_reg_alloc_pkg;

  localparam int MAX_CHUNK_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALLOC   = 2'd1,
    DEALLOC = 2'd2
  } state_t;

  typedef struct packed {
    logic                   valid;
    logic [MAX_CHUNK_W-1:0] chunk;
  } lut_entry_t;

  // Index width for a range of n items (chunks, registers, warps, entries).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold the count n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/warp_reg_alloc_free_chunk_finder.sv
// Lowest-index free chunk in the allocation map (a 1 marks a chunk in use).
module free_chunk_finder
  import warp_reg_alloc_pkg::*;
#(
  parameter int N = 16,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] map,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan from the top so the lowest free index is the last one kept.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx   = map[i] ? idx : W'(i);
      found = found | ~map[i];
    end
  end

endmodule

// File: rtl/warp_reg_alloc.sv
// Register-file chunk allocator: grants chunks to warps, frees them on exit,
// and translates logical to physical register numbers.
module warp_reg_alloc
  import warp_reg_alloc_pkg::*;
#(
  parameter int NUM_WARPS       = 8,
  parameter int NUM_CHUNKS      = 16,
  parameter int CHUNK_REGS      = 2,
  parameter int CHUNKS_PER_WARP = 4,
  parameter int SWID_W          = 32
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            alloc_valid,
  output logic                                            alloc_ready,
  input  logic [idx_w(NUM_WARPS)-1:0]                     alloc_hw_warp,
  input  logic [SWID_W-1:0]                               alloc_sw_warp,
  input  logic [cnt_w(CHUNKS_PER_WARP*CHUNK_REGS)-1:0]    alloc_nreg,
  output logic                                            alloc_done,
  output logic                                            alloc_ok,
  input  logic                                            exit_valid,
  output logic                                            exit_ready,
  input  logic [idx_w(NUM_WARPS)-1:0]                     exit_warp,
  output logic                                            exit_done,
  output logic [cnt_w(NUM_CHUNKS*CHUNK_REGS)-1:0]         avail_regs,
  input  logic [idx_w(NUM_WARPS)-1:0]                     lk_warp,
  input  logic [cnt_w(CHUNKS_PER_WARP*CHUNK_REGS)-1:0]    lk_reg,
  output logic                                            lk_valid,
  output logic [idx_w(NUM_CHUNKS*CHUNK_REGS)-1:0]         lk_phys_reg,
  input  logic [idx_w(NUM_WARPS)-1:0]                     swid_warp,
  output logic [SWID_W-1:0]                               swid_out
);

  localparam int WW       = idx_w(NUM_WARPS);
  localparam int NRW      = cnt_w(CHUNKS_PER_WARP * CHUNK_REGS);
  localparam int AW       = cnt_w(NUM_CHUNKS * CHUNK_REGS);
  localparam int PW       = idx_w(NUM_CHUNKS * CHUNK_REGS);
  localparam int CW       = idx_w(NUM_CHUNKS);
  localparam int FW       = cnt_w(NUM_CHUNKS);
  localparam int KW       = idx_w(CHUNKS_PER_WARP);
  localparam int MAX_REGS = CHUNKS_PER_WARP * CHUNK_REGS;

  state_t             state;
  logic [NUM_CHUNKS-1:0] map;
  logic [FW-1:0]      free_cnt;
  lut_entry_t         lut [NUM_WARPS][CHUNKS_PER_WARP];
  logic [SWID_W-1:0]  swid [NUM_WARPS];
  logic [WW-1:0]      cur_warp;
  logic [KW-1:0]      k;
  logic [NRW-1:0]     need_left;
  logic               rej;

  logic [CW-1:0]      free_idx;
  logic               found;
  logic [NRW-1:0]     need;
  logic               warp_busy;
  logic               alloc_reject;
  logic [NRW-1:0]     lk_entry;
  logic [NRW-1:0]     lk_off;
  logic               lk_in_range;
  lut_entry_t         lk_sel;
  lut_entry_t         dealloc_ent;
  logic [CW-1:0]      dealloc_chunk;

  free_chunk_finder #(
    .N(NUM_CHUNKS),
    .W(CW)
  ) u_finder (
    .map  (map),
    .idx  (free_idx),
    .found(found)
  );

  assign exit_ready  = !rst && (state == IDLE);
  assign alloc_ready = !rst && (state == IDLE) && !exit_valid;

  assign need = NRW'((32'(alloc_nreg) + 32'(CHUNK_REGS - 1)) / 32'(CHUNK_REGS));

  // A warp may only be granted once until it exits.
  always_comb begin
    warp_busy = 1'b0;
    for (int i = 0; i < CHUNKS_PER_WARP; i++) begin
      warp_busy = warp_busy | lut[alloc_hw_warp][i].valid;
    end
  end

  assign alloc_reject = (32'(alloc_nreg) > 32'(MAX_REGS)) ||
                        (32'(need) > 32'(free_cnt)) || warp_busy;

  assign lk_entry    = lk_reg / NRW'(CHUNK_REGS);
  assign lk_off      = lk_reg % NRW'(CHUNK_REGS);
  assign lk_in_range = 32'(lk_entry) < 32'(CHUNKS_PER_WARP);
  assign lk_sel      = lut[lk_warp][lk_entry[KW-1:0]];

  assign dealloc_ent   = lut[cur_warp][k];
  assign dealloc_chunk = CW'(dealloc_ent.chunk);

  // Allocation FSM; rejects and zero-size grants still spend one ALLOC cycle
  // so that every request completes with a done pulse one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      map        <= '0;
      free_cnt   <= FW'(NUM_CHUNKS);
      avail_regs <= AW'(NUM_CHUNKS * CHUNK_REGS);
      cur_warp   <= '0;
      k          <= '0;
      need_left  <= '0;
      rej        <= 1'b0;
      alloc_done <= 1'b0;
      alloc_ok   <= 1'b0;
      exit_done  <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        swid[w] <= '0;
        for (int e = 0; e < CHUNKS_PER_WARP; e++) begin
          lut[w][e] <= '0;
        end
      end
    end else begin
      alloc_done <= 1'b0;
      alloc_ok   <= 1'b0;
      exit_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (exit_valid) begin
            state    <= DEALLOC;
            cur_warp <= exit_warp;
            k        <= '0;
          end else if (alloc_valid) begin
            state    <= ALLOC;
            cur_warp <= alloc_hw_warp;
            k        <= '0;
            rej      <= alloc_reject;
            if (alloc_reject) begin
              need_left <= '0;
            end else begin
              need_left           <= need;
              swid[alloc_hw_warp] <= alloc_sw_warp;
            end
          end
        end
        ALLOC: begin
          if (need_left == '0) begin
            alloc_done <= 1'b1;
            alloc_ok   <= !rej;
            state      <= IDLE;
          end else if (found) begin
            map[free_idx]    <= 1'b1;
            lut[cur_warp][k] <= '{valid: 1'b1, chunk: MAX_CHUNK_W'(free_idx)};
            k                <= k + KW'(1);
            free_cnt         <= free_cnt - FW'(1);
            avail_regs       <= avail_regs - AW'(CHUNK_REGS);
            need_left        <= need_left - NRW'(1);
            if (need_left == NRW'(1)) begin
              alloc_done <= 1'b1;
              alloc_ok   <= 1'b1;
              state      <= IDLE;
            end
          end else begin
            // Unreachable while the free count is honoured at accept.
            alloc_done <= 1'b1;
            alloc_ok   <= 1'b0;
            state      <= IDLE;
          end
        end
        DEALLOC: begin
          if (dealloc_ent.valid) begin
            map[dealloc_chunk] <= 1'b0;
            lut[cur_warp][k]   <= '0;
            free_cnt           <= free_cnt + FW'(1);
            avail_regs         <= avail_regs + AW'(CHUNK_REGS);
          end
          k <= k + KW'(1);
          if (k == KW'(CHUNKS_PER_WARP - 1)) begin
            exit_done      <= 1'b1;
            swid[cur_warp] <= '0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Translation and special-register readback see state before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lk_valid    <= 1'b0;
      lk_phys_reg <= '0;
      swid_out    <= '0;
    end else begin
      lk_valid    <= lk_sel.valid && lk_in_range;
      lk_phys_reg <= PW'(lk_sel.chunk) * PW'(CHUNK_REGS) + PW'(lk_off);
      swid_out    <= swid[swid_warp];
    end
  end

endmodule

// File: tb/tb_warp_reg_alloc.sv
// Directed self-checking bench for warp_reg_alloc with default parameters.
module tb_warp_reg_alloc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [2:0]  alloc_hw_warp = 3'd0;
  logic [31:0] alloc_sw_warp = 32'd0;
  logic [3:0]  alloc_nreg = 4'd0;
  logic        alloc_done;
  logic        alloc_ok;
  logic        exit_valid = 1'b0;
  logic        exit_ready;
  logic [2:0]  exit_warp = 3'd0;
  logic        exit_done;
  logic [5:0]  avail_regs;
  logic [2:0]  lk_warp = 3'd0;
  logic [3:0]  lk_reg = 4'd0;
  logic        lk_valid;
  logic [4:0]  lk_phys_reg;
  logic [2:0]  swid_warp = 3'd0;
  logic [31:0] swid_out;

  int checks = 0;
  int errors = 0;

  warp_reg_alloc dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_hw_warp(alloc_hw_warp), .alloc_sw_warp(alloc_sw_warp),
    .alloc_nreg(alloc_nreg), .alloc_done(alloc_done), .alloc_ok(alloc_ok),
    .exit_valid(exit_valid), .exit_ready(exit_ready), .exit_warp(exit_warp),
    .exit_done(exit_done), .avail_regs(avail_regs),
    .lk_warp(lk_warp), .lk_reg(lk_reg), .lk_valid(lk_valid),
    .lk_phys_reg(lk_phys_reg), .swid_warp(swid_warp), .swid_out(swid_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; alloc_valid = 1'b0; exit_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // lat = edges after accept until alloc_done is seen, -1 if never.
  task automatic do_alloc(input int w, input int sw, input int nreg,
                          output int lat, output logic ok);
    int n;
    @(negedge clk);
    alloc_valid = 1'b1; alloc_hw_warp = 3'(w);
    alloc_sw_warp = 32'(sw); alloc_nreg = 4'(nreg);
    #1;
    n = 0;
    while (!alloc_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk); #1 alloc_valid = 1'b0;
    lat = -1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (alloc_done && lat < 0) begin
        lat = i; ok = alloc_ok;
      end
    end
  endtask

  task automatic do_exit(input int w, output int lat);
    int n;
    @(negedge clk);
    exit_valid = 1'b1; exit_warp = 3'(w);
    #1;
    n = 0;
    while (!exit_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk); #1 exit_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (exit_done && lat < 0) lat = i;
    end
  endtask

  task automatic lookup(input int w, input int r, output logic v, output logic [4:0] p);
    @(negedge clk);
    lk_warp = 3'(w); lk_reg = 4'(r);
    @(negedge clk);
    v = lk_valid; p = lk_phys_reg;
  endtask

  task automatic read_swid(input int w, output logic [31:0] s);
    @(negedge clk);
    swid_warp = 3'(w);
    @(negedge clk);
    s = swid_out;
  endtask

  task automatic test_reset();
    logic v; logic [4:0] p; logic [31:0] s;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (alloc_ready !== 1'b0 || exit_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_low: alloc_ready=%b exit_ready=%b want 0 0", alloc_ready, exit_ready);
    end
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if (avail_regs !== 6'd32) begin
      errors++; $display("FAIL reset_avail: got %0d want 32", avail_regs);
    end
    checks++;
    if (alloc_ready !== 1'b1 || exit_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: alloc_ready=%b exit_ready=%b want 1 1", alloc_ready, exit_ready);
    end
    checks++;
    if (alloc_done !== 1'b0 || alloc_ok !== 1'b0 || exit_done !== 1'b0 || swid_out !== 32'd0) begin
      errors++; $display("FAIL reset_outputs: done=%b ok=%b exit_done=%b swid=%h want 0", alloc_done, alloc_ok, exit_done, swid_out);
    end
    for (int w = 0; w < 8; w++) begin
      lookup(w, 0, v, p);
      checks++;
      if (v !== 1'b0) begin
        errors++; $display("FAIL reset_lk_valid warp %0d: got %b want 0", w, v);
      end
    end
    read_swid(5, s);
    checks++;
    if (s !== 32'd0) begin
      errors++; $display("FAIL reset_swid: got %h want 0", s);
    end
  endtask

  task automatic test_alloc_basic();
    logic v; logic [4:0] p; logic [31:0] s;
    apply_reset();
    @(negedge clk);
    alloc_valid = 1'b1; alloc_hw_warp = 3'd3; alloc_sw_warp = 32'hCAFE0003; alloc_nreg = 4'd5;
    @(posedge clk); #1 alloc_valid = 1'b0;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (avail_regs !== 6'(32 - 2 * i)) begin
        errors++; $display("FAIL alloc5_avail E%0d: got %0d want %0d", i, avail_regs, 32 - 2 * i);
      end
      checks++;
      if (alloc_done !== (i == 3)) begin
        errors++; $display("FAIL alloc5_done E%0d: got %b want %b", i, alloc_done, (i == 3));
      end
    end
    checks++;
    if (alloc_ok !== 1'b1) begin
      errors++; $display("FAIL alloc5_ok: got %b want 1", alloc_ok);
    end
    lookup(3, 4, v, p);
    checks++;
    if (v !== 1'b1 || p !== 5'd4) begin
      errors++; $display("FAIL lk_w3_r4: valid=%b phys=%0d want 1 4", v, p);
    end
    lookup(3, 5, v, p);
    checks++;
    if (v !== 1'b1 || p !== 5'd5) begin
      errors++; $display("FAIL lk_w3_r5: valid=%b phys=%0d want 1 5", v, p);
    end
    lookup(3, 6, v, p);
    checks++;
    if (v !== 1'b0) begin
      errors++; $display("FAIL lk_w3_r6: valid=%b want 0", v);
    end
    lookup(3, 8, v, p);
    checks++;
    if (v !== 1'b0) begin
      errors++; $display("FAIL lk_w3_r8_range: valid=%b want 0", v);
    end
    read_swid(3, s);
    checks++;
    if (s !== 32'hCAFE0003) begin
      errors++; $display("FAIL swid_w3: got %h want cafe0003", s);
    end
  endtask

  task automatic test_capacity();
    int lat; logic ok; logic v; logic [4:0] p;
    apply_reset();
    for (int w = 0; w < 4; w++) begin
      do_alloc(w, 100 + w, 8, lat, ok);
      checks++;
      if (lat !== 4 || ok !== 1'b1) begin
        errors++; $display("FAIL full_alloc warp %0d: lat=%0d ok=%b want 4 1", w, lat, ok);
      end
    end
    checks++;
    if (avail_regs !== 6'd0) begin
      errors++; $display("FAIL full_avail: got %0d want 0", avail_regs);
    end
    do_alloc(4, 104, 1, lat, ok);
    checks++;
    if (lat !== 1 || ok !== 1'b0 || avail_regs !== 6'd0) begin
      errors++; $display("FAIL full_reject: lat=%0d ok=%b avail=%0d want 1 0 0", lat, ok, avail_regs);
    end
    do_alloc(4, 104, 9, lat, ok);
    checks++;
    if (lat !== 1 || ok !== 1'b0) begin
      errors++; $display("FAIL full_nreg9: lat=%0d ok=%b want 1 0", lat, ok);
    end
    lookup(3, 7, v, p);
    checks++;
    if (v !== 1'b1 || p !== 5'd31) begin
      errors++; $display("FAIL lk_w3_r7_top: valid=%b phys=%0d want 1 31", v, p);
    end
    lookup(4, 0, v, p);
    checks++;
    if (v !== 1'b0) begin
      errors++; $display("FAIL lk_w4_rejected: valid=%b want 0", v);
    end
  endtask

  task automatic test_reject_cases();
    int lat; logic ok; logic v; logic [4:0] p; logic [31:0] s;
    apply_reset();
    do_alloc(5, 55, 9, lat, ok);
    checks++;
    if (lat !== 1 || ok !== 1'b0 || avail_regs !== 6'd32) begin
      errors++; $display("FAIL nreg9_reject: lat=%0d ok=%b avail=%0d want 1 0 32", lat, ok, avail_regs);
    end
    do_alloc(6, 32'h66, 0, lat, ok);
    checks++;
    if (lat !== 1 || ok !== 1'b1 || avail_regs !== 6'd32) begin
      errors++; $display("FAIL nreg0_grant: lat=%0d ok=%b avail=%0d want 1 1 32", lat, ok, avail_regs);
    end
    read_swid(6, s);
    checks++;
    if (s !== 32'h66) begin
      errors++; $display("FAIL nreg0_swid: got %h want 66", s);
    end
    lookup(6, 0, v, p);
    checks++;
    if (v !== 1'b0) begin
      errors++; $display("FAIL nreg0_no_entry: valid=%b want 0", v);
    end
    do_alloc(3, 33, 2, lat, ok);
    do_alloc(3, 34, 2, lat, ok);
    checks++;
    if (ok !== 1'b0 || avail_regs !== 6'd30) begin
      errors++; $display("FAIL busy_warp_reject: ok=%b avail=%0d want 0 30", ok, avail_regs);
    end
    do_alloc(7, 77, 8, lat, ok);
    checks++;
    if (lat !== 4 || ok !== 1'b1 || avail_regs !== 6'd22) begin
      errors++; $display("FAIL nreg8_max: lat=%0d ok=%b avail=%0d want 4 1 22", lat, ok, avail_regs);
    end
  endtask

  task automatic test_exit_reuse();
    int lat; logic ok; logic v; logic [4:0] p;
    int regs [4] = '{0, 2, 4, 5};
    int exp_p [4] = '{0, 2, 8, 9};
    apply_reset();
    do_alloc(0, 10, 4, lat, ok);
    do_alloc(1, 11, 4, lat, ok);
    checks++;
    if (avail_regs !== 6'd24) begin
      errors++; $display("FAIL pre_exit_avail: got %0d want 24", avail_regs);
    end
    do_exit(0, lat);
    checks++;
    if (lat !== 4 || avail_regs !== 6'd28) begin
      errors++; $display("FAIL exit_w0: lat=%0d avail=%0d want 4 28", lat, avail_regs);
    end
    do_alloc(2, 12, 6, lat, ok);
    checks++;
    if (lat !== 3 || ok !== 1'b1 || avail_regs !== 6'd22) begin
      errors++; $display("FAIL reuse_alloc: lat=%0d ok=%b avail=%0d want 3 1 22", lat, ok, avail_regs);
    end
    // Back-to-back lookups, one result per cycle.
    @(negedge clk);
    lk_warp = 3'd2; lk_reg = 4'(regs[0]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (lk_valid !== 1'b1 || lk_phys_reg !== 5'(exp_p[i])) begin
        errors++; $display("FAIL pipe_lk r%0d: valid=%b phys=%0d want 1 %0d", regs[i], lk_valid, lk_phys_reg, exp_p[i]);
      end
      if (i < 3) lk_reg = 4'(regs[i + 1]);
    end
    lookup(0, 0, v, p);
    checks++;
    if (v !== 1'b0) begin
      errors++; $display("FAIL exited_w0_lk: valid=%b want 0", v);
    end
    lookup(1, 3, v, p);
    checks++;
    if (v !== 1'b1 || p !== 5'd7) begin
      errors++; $display("FAIL w1_r3: valid=%b phys=%0d want 1 7", v, p);
    end
  endtask

  task automatic test_priority();
    int lat; logic ok; logic v; logic [4:0] p; logic [31:0] s;
    int ex_at; int ready_bad;
    apply_reset();
    do_alloc(1, 32'hAB, 2, lat, ok);
    read_swid(1, s);
    checks++;
    if (s !== 32'hAB) begin
      errors++; $display("FAIL prio_swid_before: got %h want ab", s);
    end
    @(negedge clk);
    exit_valid = 1'b1; exit_warp = 3'd1;
    alloc_valid = 1'b1; alloc_hw_warp = 3'd5; alloc_sw_warp = 32'h55; alloc_nreg = 4'd2;
    #1;
    checks++;
    if (alloc_ready !== 1'b0 || exit_ready !== 1'b1) begin
      errors++; $display("FAIL prio_ready: alloc_ready=%b exit_ready=%b want 0 1", alloc_ready, exit_ready);
    end
    @(posedge clk); #1 exit_valid = 1'b0;
    ex_at = -1; ready_bad = 0;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (exit_done && ex_at < 0) ex_at = i;
      if (i < 4 && alloc_ready !== 1'b0) ready_bad++;
    end
    checks++;
    if (ex_at !== 4 || ready_bad !== 0) begin
      errors++; $display("FAIL prio_exit: done_at=%0d ready_high_cycles=%0d want 4 0", ex_at, ready_bad);
    end
    checks++;
    if (alloc_ready !== 1'b1) begin
      errors++; $display("FAIL prio_ready_after: got %b want 1", alloc_ready);
    end
    @(posedge clk); #1 alloc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (alloc_done !== 1'b0) begin
      errors++; $display("FAIL prio_alloc_early: done=%b want 0", alloc_done);
    end
    @(negedge clk);
    checks++;
    if (alloc_done !== 1'b1 || alloc_ok !== 1'b1) begin
      errors++; $display("FAIL prio_alloc_done: done=%b ok=%b want 1 1", alloc_done, alloc_ok);
    end
    read_swid(1, s);
    checks++;
    if (s !== 32'd0) begin
      errors++; $display("FAIL prio_swid_cleared: got %h want 0", s);
    end
    lookup(5, 1, v, p);
    checks++;
    if (v !== 1'b1 || p !== 5'd1) begin
      errors++; $display("FAIL prio_w5_r1: valid=%b phys=%0d want 1 1", v, p);
    end
  endtask

  task automatic test_rst_abort();
    int lat; logic ok; logic v; logic [4:0] p; logic [31:0] s;
    int done_seen;
    apply_reset();
    @(negedge clk);
    alloc_valid = 1'b1; alloc_hw_warp = 3'd2; alloc_sw_warp = 32'h77; alloc_nreg = 4'd6;
    @(posedge clk); #1 alloc_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (alloc_done !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++; $display("FAIL abort_no_done: done cycles=%0d want 0", done_seen);
    end
    checks++;
    if (avail_regs !== 6'd32 || alloc_ready !== 1'b1) begin
      errors++; $display("FAIL abort_state: avail=%0d ready=%b want 32 1", avail_regs, alloc_ready);
    end
    lookup(2, 0, v, p);
    checks++;
    if (v !== 1'b0) begin
      errors++; $display("FAIL abort_lk: valid=%b want 0", v);
    end
    read_swid(2, s);
    checks++;
    if (s !== 32'd0) begin
      errors++; $display("FAIL abort_swid: got %h want 0", s);
    end
    do_alloc(2, 32'h78, 2, lat, ok);
    checks++;
    if (lat !== 1 || ok !== 1'b1 || avail_regs !== 6'd30) begin
      errors++; $display("FAIL abort_realloc: lat=%0d ok=%b avail=%0d want 1 1 30", lat, ok, avail_regs);
    end
  endtask

  initial begin
    test_reset();
    test_alloc_basic();
    test_capacity();
    test_reject_cases();
    test_exit_reuse();
    test_priority();
    test_rst_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
